// File: rtl/mem_access_unit.sv
// Load/store memory access unit: decodes MIPS-style lb/lh/lw/sb/sh/sw, drives a
// req/ack memory handshake with big-endian byte lanes, and aborts on misalignment or timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rt_reg,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        timeout
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]  sz_q, off_q;
    logic        accept_c, ack_hit_c, to_hit_c;
    logic        valid_c, mis_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Opcode decode and alignment check on the live request inputs
    always_comb begin
        valid_c = 1'b0;
        case (opcode)
            6'b100000, 6'b100001, 6'b100011,
            6'b101000, 6'b101001, 6'b101011: valid_c = 1'b1;
            default:                         valid_c = 1'b0;
        endcase
        case (opcode[1:0])
            2'b01:   mis_c = ALU_result[0];
            2'b11:   mis_c = |ALU_result[1:0];
            default: mis_c = 1'b0;
        endcase
        case (opcode[1:0])
            2'b00:   be_c = 4'b1000 >> ALU_result[1:0];
            2'b01:   be_c = ALU_result[1] ? 4'b0011 : 4'b1100;
            default: be_c = 4'b1111;
        endcase
        case (opcode[1:0])
            2'b00:   wdata_c = {4{rt_reg[7:0]}};
            2'b01:   wdata_c = {2{rt_reg[15:0]}};
            default: wdata_c = rt_reg;
        endcase
    end

    // Big-endian lane extraction of the returned word using the captured size/offset
    always_comb begin
        case (off_q)
            2'd0:    byte_c = mem_rdata[31:24];
            2'd1:    byte_c = mem_rdata[23:16];
            2'd2:    byte_c = mem_rdata[15:8];
            default: byte_c = mem_rdata[7:0];
        endcase
        half_c = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (sz_q)
            2'b00:   load_c = {{24{byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{half_c[15]}}, half_c};
            default: load_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        ack_hit_c  = 1'b0;
        to_hit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start && valid_c) begin
                    accept_c   = 1'b1;
                    state_next = mis_c ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ack_hit_c  = 1'b1;
                    state_next = DONE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    to_hit_c   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sz_q       <= '0;
            off_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            load_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            mem_req    <= (state_next == REQ);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
            misaligned <= accept_c && mis_c;
            timeout    <= to_hit_c;
            if (accept_c) begin
                cnt       <= '0;
                sz_q      <= opcode[1:0];
                off_q     <= ALU_result[1:0];
                mem_we    <= opcode[3];
                mem_addr  <= {ALU_result[31:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
            end else if (state == REQ) begin
                cnt <= cnt + CW'(1);
            end
            if (ack_hit_c && !mem_we)
                load_data <= load_c;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL be the maximum number of REQ-state cycles to wait for mem_ack before aborting.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one memory access using the current opcode, ALU_result and rt_reg.
REQ-005 opcode  input  6  SHALL select the access: lb 100000, lh 100001, lw 100011, sb 101000, sh 101001, sw 101011.
REQ-006 ALU_result  input  32  SHALL be the byte address computed upstream.
REQ-007 rt_reg  input  32  SHALL be the store data.
REQ-008 mem_rdata  input  32  SHALL be the read word from memory.
REQ-009 mem_ack  input  1  SHALL complete the memory handshake.
REQ-010 mem_req  output  1  SHALL be the memory request.
REQ-011 mem_we  output  1  SHALL be 1 for stores and 0 for loads.
REQ-012 mem_addr  output  32  SHALL be {ALU_result[31:2],2'b00}.
REQ-013 mem_be  output  4  SHALL be the byte-lane enables; bit 3 is bits 31:24.
REQ-014 mem_wdata  output  32  SHALL be the lane-replicated store data.
REQ-015 load_data  output  32  SHALL be the extracted, sign-extended load result.
REQ-016 busy  output  1  SHALL be 1 in any state other than IDLE.
REQ-017 done  output  1  SHALL be a one-cycle completion pulse.
REQ-018 misaligned  output  1  SHALL flag an aborted misaligned access; valid while done=1.
REQ-019 timeout  output  1  SHALL flag an access aborted for lack of mem_ack; valid while done=1.

Function
REQ-020 FSM states SHALL be IDLE, REQ and DONE.
REQ-021 IDLE SHALL transition on start=1 with a valid opcode: to DONE with misaligned=1 if lh has addr[0]=1 or lw/sw has addr[1:0]!=0 (sh likewise addr[0]); otherwise to REQ.
REQ-022 start with an invalid opcode, or start while busy=1, SHALL be ignored.
REQ-023 opcode, address and rt_reg SHALL be captured on the accepting edge; mem_* outputs SHALL derive only from captured values.
REQ-024 mem_req SHALL be 1 in every REQ cycle; mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable while mem_req=1.
REQ-025 mem_ack SHALL be sampled only while in REQ; an ack there SHALL move the FSM to DONE, and mem_req SHALL be 0 in the next cycle.
REQ-026 The FSM SHALL count REQ cycles; if TIMEOUT_CYCLES elapse without ack, it SHALL go to DONE with timeout=1 and not update load_data.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Minimum latency SHALL be: start at edge N, mem_req at N+1, ack sampled at N+1, done at N+2.
REQ-029 Byte lanes SHALL be big-endian:
- offset 0 maps to bits 31:24;
- byte mem_be: 1000/0100/0010/0001 for offsets 0-3;
- half mem_be: 1100 for offset 0, 0011 for offset 2;
- word mem_be: 1111.
REQ-030 mem_wdata SHALL be:
- sb: {4{rt[7:0]}};
- sh: {2{rt[15:0]}};
- sw: rt.
REQ-031 On ack, load_data SHALL be the selected lane of mem_rdata, sign-extended to 32 bits for lb/lh, and full mem_rdata for lw.
REQ-032 load_data SHALL hold its value until the next successful load; stores SHALL not modify it.
REQ-033 misaligned and timeout SHALL be 0 whenever done=0.

Reset
REQ-034 Asserting rst_n=0 SHALL immediately force IDLE and clear all outputs: mem_req, mem_we, done, busy, misaligned and timeout to 0; mem_addr, mem_be, mem_wdata and load_data to 0.
REQ-035 Reset during REQ SHALL drop mem_req at once; a late mem_ack after reset SHALL be ignored.

Verification
REQ-036 lb at addr 0x00000102, mem_rdata=0x11228344 with ack in the first REQ cycle -> mem_be=0010, mem_addr=0x00000100, load_data=0xFFFFFF83, done at N+2.
REQ-037 sh at addr 0x00000006, rt=0xAAAA1234 -> mem_we=1, mem_be=0011, mem_wdata=0x12341234.
REQ-038 lw at addr 0x00000005 -> no mem_req, done=1 with misaligned=1 at N+1, load_data unchanged.
REQ-039 sw with mem_ack held low -> mem_req stays high for 16 cycles, then done=1 with timeout=1 and mem_req=0.
REQ-040 lh at addr 0x00000000 with ack delayed 3 cycles and a second start during busy -> a single access occurs, mem_rdata=0x7FFF0000 gives load_data=0x00007FFF, and the second start is ignored.
REQ-041 rst_n pulled low in the second REQ cycle -> mem_req and busy are 0 immediately, a following ack produces no done, and a new start then works normally.
